// File: rtl/wb_intercon_n_if.sv
// Bus bundle for wb_intercon_n: the single master port plus the fanned-out
// slave ports. Signal names keep the interconnect's own _i/_o view.
//   master : the bus master (core) side
//   slave  : the slave devices side
//   fabric : the interconnect itself
interface wb_intercon_n_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADR_W      = 31,
  parameter int DAT_W      = 32,
  parameter int SEL_W      = 2
);
  logic [ADR_W-1:0]            wbm_adr_i;
  logic [DAT_W-1:0]            wbm_dat_i;
  logic [SEL_W-1:0]            wbm_sel_i;
  logic                        wbm_we_i;
  logic                        wbm_cyc_i;
  logic                        wbm_stb_i;
  logic [DAT_W-1:0]            wbm_dat_o;
  logic                        wbm_ack_o;
  logic                        wbm_err_o;

  logic [ADR_W-1:0]            wbs_adr_o;
  logic [DAT_W-1:0]            wbs_dat_o;
  logic [SEL_W-1:0]            wbs_sel_o;
  logic                        wbs_we_o;
  logic [NUM_SLAVES-1:0]       wbs_cyc_o;
  logic [NUM_SLAVES-1:0]       wbs_stb_o;
  logic [NUM_SLAVES*DAT_W-1:0] wbs_dat_i;
  logic [NUM_SLAVES-1:0]       wbs_ack_i;

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o
  );

  modport slave (
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    output wbs_dat_i, wbs_ack_i
  );

  modport fabric (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    input  wbs_dat_i, wbs_ack_i
  );
endinterface

// File: rtl/wb_intercon_n.sv
// wb_intercon_n: Wishbone shared-bus interconnect, one master to NUM_SLAVES
// slaves. Address/mask decode (lowest index wins), registered decode FSM,
// undecoded accesses end in a one-cycle bus error.
// Optional feature macro: WB_INTERCON_TIMEOUT_EN -- when defined, a transfer
// that sees no slave ack for TIMEOUT cycles is ended with a bus error.
// The default SLAVE_ADDR table holds sixteen entries (i << 27, byte address
// [31:28] == i) and is trimmed to NUM_SLAVES entries.
module wb_intercon_n #(
  parameter int NUM_SLAVES = 4,
  parameter int ADR_W      = 31,
  parameter int DAT_W      = 32,
  parameter int SEL_W      = 2,
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_ADDR = (NUM_SLAVES*ADR_W)'({
    31'h7800_0000, 31'h7000_0000, 31'h6800_0000, 31'h6000_0000,
    31'h5800_0000, 31'h5000_0000, 31'h4800_0000, 31'h4000_0000,
    31'h3800_0000, 31'h3000_0000, 31'h2800_0000, 31'h2000_0000,
    31'h1800_0000, 31'h1000_0000, 31'h0800_0000, 31'h0000_0000}),
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_MASK =
    {NUM_SLAVES{ADR_W'(31'h7800_0000)}},
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_intercon_n_if.fabric  bus
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] ERR    = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [NUM_SLAVES-1:0] hit;
  logic [IDX_W-1:0]      decIdx;
  logic                  anyHit;
  logic                  selAck;

  // Master write-side signals are broadcast unchanged to every slave.
  assign bus.wbs_adr_o = bus.wbm_adr_i;
  assign bus.wbs_dat_o = bus.wbm_dat_i;
  assign bus.wbs_sel_o = bus.wbm_sel_i;
  assign bus.wbs_we_o  = bus.wbm_we_i;

  // Address decode: compare each slave window, then pick the lowest hit.
  always_comb begin
    hit    = '0;
    decIdx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = ((bus.wbm_adr_i & SLAVE_MASK[i*ADR_W +: ADR_W]) ==
                SLAVE_ADDR[i*ADR_W +: ADR_W]);
    end
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) decIdx = IDX_W'(i);
    end
  end

  assign anyHit = |hit;
  assign selAck = bus.wbs_ack_i[sel_q] & bus.wbm_stb_i;

`ifdef WB_INTERCON_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TO_W-1:0] timer_q, timer_d;
  logic            timeoutHit;

  assign timeoutHit = (timer_q == TO_W'(TIMEOUT - 1));

  // Stall counter: zero outside ACTIVE, counts ACTIVE cycles without an ack.
  always_comb begin
    timer_d = '0;
    if (state_q == ACTIVE && !selAck) timer_d = timer_q + TO_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  logic timeoutHit;

  assign timeoutHit = 1'b0;
`endif

  // Next-state logic: latch the decoded slave on a request, release on ack
  // or cyc drop; an ack always wins over a simultaneous stall limit.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
          if (anyHit) begin
            state_d = ACTIVE;
            sel_d   = decIdx;
          end else begin
            state_d = ERR;
          end
        end
      end
      ACTIVE: begin
        if (selAck || !bus.wbm_cyc_i) state_d = IDLE;
        else if (timeoutHit)          state_d = ERR;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and selected-slave registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Output steering: only the latched slave sees cyc/stb, and only its
  // ack and data reach the master; ERR raises the bus error alone.
  always_comb begin
    bus.wbs_cyc_o = '0;
    bus.wbs_stb_o = '0;
    bus.wbm_ack_o = 1'b0;
    bus.wbm_err_o = 1'b0;
    bus.wbm_dat_o = '0;
    case (state_q)
      ACTIVE: begin
        bus.wbs_cyc_o[sel_q] = bus.wbm_cyc_i;
        bus.wbs_stb_o[sel_q] = bus.wbm_stb_i;
        bus.wbm_ack_o        = selAck;
        bus.wbm_dat_o        = bus.wbs_dat_i[sel_q*DAT_W +: DAT_W];
      end
      ERR:     bus.wbm_err_o = 1'b1;
      default: ;
    endcase
  end

endmodule
